// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter for the icache/dcache of two cores.
// Data beats instruction traffic; one shared round-robin pointer picks the core.
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [1:0]          iREN,
  input  logic [2*WORD_W-1:0] iaddr,
  input  logic [1:0]          dREN,
  input  logic [1:0]          dWEN,
  input  logic [2*WORD_W-1:0] daddr,
  input  logic [2*WORD_W-1:0] dstore,
  output logic [1:0]          iwait,
  output logic [1:0]          dwait,
  output logic [2*WORD_W-1:0] iload,
  output logic [2*WORD_W-1:0] dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [WORD_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore,
  input  logic [WORD_W-1:0]   ramload,
  input  logic [1:0]          ramstate,
  output logic [1:0]          grant_id,
  output logic                grant_valid,
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, TURN} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam logic [7:0] LAST_WAIT  = 8'(TIMEOUT - 1);

  state_t      r_state, w_next_state;
  logic        r_rr, w_next_rr;
  logic [7:0]  r_count, w_next_count;
  logic [1:0]  r_grant_id, w_next_grant_id;

  logic [1:0]        w_dreq;
  logic              w_is_i, w_core, w_pick_core;
  logic              w_iren, w_dren, w_dwen, w_wants;
  logic [WORD_W-1:0] w_iaddr, w_daddr, w_dstore;

  assign w_dreq   = dREN | dWEN;
  assign w_is_i   = r_grant_id[1];
  assign w_core   = r_grant_id[0];
  assign w_iren   = iREN[w_core];
  assign w_dren   = dREN[w_core];
  assign w_dwen   = dWEN[w_core];
  assign w_iaddr  = w_core ? iaddr[2*WORD_W-1:WORD_W]  : iaddr[WORD_W-1:0];
  assign w_daddr  = w_core ? daddr[2*WORD_W-1:WORD_W]  : daddr[WORD_W-1:0];
  assign w_dstore = w_core ? dstore[2*WORD_W-1:WORD_W] : dstore[WORD_W-1:0];
  assign w_wants  = w_is_i ? w_iren : (w_dren | w_dwen);
  assign grant_id = r_grant_id;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_rr       <= 1'b0;
      r_count    <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_next_state;
      r_rr       <= w_next_rr;
      r_count    <= w_next_count;
      r_grant_id <= w_next_grant_id;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_rr       = r_rr;
    w_next_count    = r_count;
    w_next_grant_id = r_grant_id;
    w_pick_core     = 1'b0;
    iwait           = 2'b11;
    dwait           = 2'b11;
    iload           = '0;
    dload           = '0;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = '0;
    ramstore        = '0;
    grant_valid     = 1'b0;
    timeout_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (|w_dreq) begin
          w_pick_core     = w_dreq[r_rr] ? r_rr : ~r_rr;
          w_next_grant_id = {1'b0, w_pick_core};
          w_next_count    = '0;
          w_next_state    = ACTIVE;
        end else if (|iREN) begin
          w_pick_core     = iREN[r_rr] ? r_rr : ~r_rr;
          w_next_grant_id = {1'b1, w_pick_core};
          w_next_count    = '0;
          w_next_state    = ACTIVE;
        end
      end

      ACTIVE: begin
        grant_valid = 1'b1;
        if (w_is_i) begin
          ramREN  = w_iren;
          ramaddr = w_iaddr;
        end else begin
          ramaddr = w_daddr;
          if (w_dwen) begin
            ramWEN   = 1'b1;
            ramstore = w_dstore;
          end else begin
            ramREN = w_dren;
          end
        end

        // Completion outranks error, drop and watchdog in the same cycle.
        if (ramstate == RAM_ACCESS) begin
          if (w_is_i) begin
            iwait[w_core] = 1'b0;
            if (w_core) iload[2*WORD_W-1:WORD_W] = ramload;
            else        iload[WORD_W-1:0]        = ramload;
          end else begin
            dwait[w_core] = 1'b0;
            if (!w_dwen) begin
              if (w_core) dload[2*WORD_W-1:WORD_W] = ramload;
              else        dload[WORD_W-1:0]        = ramload;
            end
          end
          w_next_rr    = ~w_core;
          w_next_state = TURN;
        end else begin
          w_next_count = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
          if (ramstate == RAM_ERROR) begin
            timeout_err  = 1'b1;
            w_next_state = IDLE;
          end else if (!w_wants) begin
            w_next_state = IDLE;
          end else if (r_count >= LAST_WAIT) begin
            timeout_err  = 1'b1;
            w_next_state = IDLE;
          end
        end
      end

      TURN: begin
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule
